// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: reads back a multiplexed, active-low 7-segment bus.
// It captures each digit's nibble once the bus has been stable for
// STABLE_CYCLES samples. Illegal patterns set a sticky error flag, and a
// frame pulse is raised once every digit has been captured.
module seg7_scan_decoder #(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NUM_DIGITS-1:0]   an_i,
  input  logic [6:0]              seg_i,
  input  logic                    clear_i,
  output logic [4*NUM_DIGITS-1:0] digits_o,
  output logic [NUM_DIGITS-1:0]   valid_o,
  output logic                    err_o,
  output logic                    frame_o
);

  localparam int unsigned SW = NUM_DIGITS + 7;
  localparam int unsigned CW = $clog2(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, HELD} state_e;

  state_e                  state_q, state_d;
  logic [SW-1:0]           samp_q, samp_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
  logic [NUM_DIGITS-1:0]   valid_q, valid_d;
  logic [NUM_DIGITS-1:0]   seen_q, seen_d;
  logic                    err_q, err_d;
  logic                    frame_q, frame_d;

  logic                    dec_legal, dec_blank;
  logic [3:0]              dec_nib;
  logic [NUM_DIGITS-1:0]   an_sel;
  logic                    changed, capture;

  // True when exactly one anode is driven low.
  function automatic logic onehot_low(input logic [NUM_DIGITS-1:0] an);
    logic [NUM_DIGITS-1:0] a;
    a = ~an;
    return (a != '0) && ((a & (a - 1'b1)) == '0);
  endfunction

  // Segment pattern of the held sample to nibble, with legal/blank flags.
  always_comb begin
    dec_legal = 1'b1;
    dec_blank = 1'b0;
    dec_nib   = '0;
    case (samp_q[6:0])
      7'b1000000: dec_nib = 4'h0;
      7'b1111001: dec_nib = 4'h1;
      7'b0100100: dec_nib = 4'h2;
      7'b0110000: dec_nib = 4'h3;
      7'b0011001: dec_nib = 4'h4;
      7'b0010010: dec_nib = 4'h5;
      7'b0000010: dec_nib = 4'h6;
      7'b0111000: dec_nib = 4'h7;
      7'b0000000: dec_nib = 4'h8;
      7'b0011000: dec_nib = 4'h9;
      7'b0001000: dec_nib = 4'hA;
      7'b0000011: dec_nib = 4'hB;
      7'b1000110: dec_nib = 4'hC;
      7'b0100001: dec_nib = 4'hD;
      7'b0000110: dec_nib = 4'hE;
      7'b0001110: dec_nib = 4'hF;
      7'b1111111: begin
        dec_legal = 1'b0;
        dec_blank = 1'b1;
      end
      default: dec_legal = 1'b0;
    endcase
  end

  // Stability counting, FSM next state, capture and frame tracking.
  always_comb begin
    samp_d   = {an_i, seg_i};
    cnt_d    = cnt_q;
    state_d  = state_q;
    digits_d = digits_q;
    valid_d  = valid_q;
    err_d    = err_q;
    seen_d   = seen_q;
    frame_d  = 1'b0;

    changed = (samp_d != samp_q);
    an_sel  = ~samp_q[SW-1:7];
    // A completed window captures even if the bus moves on that same edge.
    capture = (state_q == SETTLE) && (cnt_q == CNT_MAX);

    if (changed) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end

    if (changed) begin
      state_d = onehot_low(an_i) ? SETTLE : IDLE;
    end else if (capture) begin
      state_d = HELD;
    end else if (state_q == IDLE && onehot_low(samp_q[SW-1:7])) begin
      state_d = SETTLE;
    end

    if (capture) begin
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        if (an_sel[i]) begin
          if (dec_legal) begin
            digits_d[4*i +: 4] = dec_nib;
            valid_d[i]         = 1'b1;
          end else begin
            valid_d[i] = 1'b0;
          end
        end
      end
      if (!dec_legal && !dec_blank) begin
        err_d = 1'b1;
      end
      seen_d = seen_q | an_sel;
      if (seen_d == '1) begin
        frame_d = 1'b1;
        seen_d  = '0;
      end
    end

    if (clear_i) begin
      cnt_d    = '0;
      state_d  = IDLE;
      digits_d = '0;
      valid_d  = '0;
      err_d    = 1'b0;
      seen_d   = '0;
      frame_d  = 1'b0;
    end
  end

  // State registers; the sample resets to "all anodes off, blank".
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      samp_q   <= '1;
      cnt_q    <= '0;
      digits_q <= '0;
      valid_q  <= '0;
      err_q    <= 1'b0;
      seen_q   <= '0;
      frame_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      samp_q   <= samp_d;
      cnt_q    <= cnt_d;
      digits_q <= digits_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      seen_q   <= seen_d;
      frame_q  <= frame_d;
    end
  end

  assign digits_o = digits_q;
  assign valid_o  = valid_q;
  assign err_o    = err_q;
  assign frame_o  = frame_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder with default parameters.
module tb_seg7_scan_decoder;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [3:0]  an_i;
  logic [6:0]  seg_i;
  logic        clear_i;
  logic [15:0] digits_o;
  logic [3:0]  valid_o;
  logic        err_o;
  logic        frame_o;

  int n_vec  = 0;
  int n_miss = 0;
  int frames = 0;

  typedef struct {
    logic [3:0]  an;
    logic [6:0]  seg;
    int          n;
    logic [15:0] dig;
    logic [3:0]  val;
    logic        err;
    int          fr;
  } vec_t;

  vec_t vecs[13];

  seg7_scan_decoder #(.NUM_DIGITS(4), .STABLE_CYCLES(4)) dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .an_i     (an_i),
    .seg_i    (seg_i),
    .clear_i  (clear_i),
    .digits_o (digits_o),
    .valid_o  (valid_o),
    .err_o    (err_o),
    .frame_o  (frame_o)
  );

  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) if (frame_o === 1'b1) frames++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic hold(input logic [3:0] an, input logic [6:0] seg, input int n);
    an_i  = an;
    seg_i = seg;
    repeat (n) @(negedge clk_i);
  endtask

  initial begin
    int f0;
    vecs[0]  = '{4'hF, 7'b1111111, 4, 16'h0000, 4'b0000, 1'b0, 0};
    vecs[1]  = '{4'hE, 7'b0110000, 8, 16'h0003, 4'b0001, 1'b0, 0};
    vecs[2]  = '{4'hD, 7'b0001000, 8, 16'h00A3, 4'b0011, 1'b0, 0};
    vecs[3]  = '{4'hB, 7'b0111000, 8, 16'h07A3, 4'b0111, 1'b0, 0};
    vecs[4]  = '{4'h7, 7'b0001110, 8, 16'hF7A3, 4'b1111, 1'b0, 1};
    vecs[5]  = '{4'hD, 7'b0100100, 3, 16'hF7A3, 4'b1111, 1'b0, 0};
    vecs[6]  = '{4'hD, 7'b1111001, 6, 16'hF713, 4'b1111, 1'b0, 0};
    vecs[7]  = '{4'hB, 7'b1010101, 5, 16'hF713, 4'b1011, 1'b1, 0};
    vecs[8]  = '{4'hB, 7'b1111111, 6, 16'hF713, 4'b1011, 1'b1, 0};
    vecs[9]  = '{4'hC, 7'b0000000, 10, 16'hF713, 4'b1011, 1'b1, 0};
    vecs[10] = '{4'hE, 7'b0010010, 6, 16'hF715, 4'b1011, 1'b1, 0};
    vecs[11] = '{4'h7, 7'b1000000, 6, 16'h0715, 4'b1011, 1'b1, 1};
    vecs[12] = '{4'hE, 7'b1111001, 6, 16'h0711, 4'b1011, 1'b1, 0};

    rst_ni  = 1'b0;
    clear_i = 1'b0;
    an_i    = 4'hF;
    seg_i   = 7'b1111111;
    repeat (3) @(negedge clk_i);
    chk("rst.digits", 32'(digits_o), 32'h0);
    chk("rst.valid", 32'(valid_o), 32'h0);
    chk("rst.err", 32'(err_o), 32'h0);
    chk("rst.frame", 32'(frame_o), 32'h0);
    rst_ni = 1'b1;

    for (int i = 0; i < 13; i++) begin
      f0 = frames;
      hold(vecs[i].an, vecs[i].seg, vecs[i].n);
      chk($sformatf("v%0d.digits", i), 32'(digits_o), 32'(vecs[i].dig));
      chk($sformatf("v%0d.valid", i), 32'(valid_o), 32'(vecs[i].val));
      chk($sformatf("v%0d.err", i), 32'(err_o), 32'(vecs[i].err));
      chk($sformatf("v%0d.frames", i), 32'(frames - f0), 32'(vecs[i].fr));
    end

    // Clear on the capture edge beats the capture.
    hold(4'hF, 7'b1111111, 2);
    hold(4'hE, 7'b0010010, 4);
    chk("clr.pre_digits", 32'(digits_o), 32'h0711);
    clear_i = 1'b1;
    @(negedge clk_i);
    clear_i = 1'b0;
    chk("clr.digits", 32'(digits_o), 32'h0);
    chk("clr.valid", 32'(valid_o), 32'h0);
    chk("clr.err", 32'(err_o), 32'h0);
    hold(4'hF, 7'b1111111, 2);
    hold(4'hE, 7'b0010010, 4);
    chk("lat.before", 32'(digits_o), 32'h0);
    @(negedge clk_i);
    chk("lat.digits", 32'(digits_o), 32'h0005);
    chk("lat.valid", 32'(valid_o), 32'b0001);

    // Asynchronous reset in the middle of a window discards it.
    f0 = frames;
    hold(4'hD, 7'b0100100, 2);
    #2 rst_ni = 1'b0;
    #1;
    chk("mrst.digits", 32'(digits_o), 32'h0);
    chk("mrst.valid", 32'(valid_o), 32'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (3) @(negedge clk_i);
    chk("mrst.nocap", 32'(digits_o), 32'h0);
    repeat (2) @(negedge clk_i);
    chk("mrst.digits2", 32'(digits_o), 32'h0020);
    chk("mrst.valid2", 32'(valid_o), 32'b0010);
    chk("mrst.frames", 32'(frames - f0), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/seg7_scan_decoder.md
# seg7_scan_decoder

Receive-side counterpart of the hex-to-seven-segment encoder. The block watches a time-multiplexed, active-low 7-segment display bus (anodes plus gfedcba segments) and reconstructs the hex nibble shown on each digit. It filters out transitions with a stability window and flags illegal segment patterns. It sits beside the display driver on the board-level ALU top and gives testbenches and on-chip self-check logic a readback path for the displayed values.

## Interface
- NUM_DIGITS, default 4: number of multiplexed digits (anodes), range 1..8.
- STABLE_CYCLES, default 4: consecutive identical samples required before a capture, range 2..255.

- clk_i  input  1  system clock; all state updates on the rising edge.
- rst_ni  input  1  reset, asynchronous, active-low.
- an_i  input  NUM_DIGITS  anode selects, active-low; bit i low selects digit i.
- seg_i  input  7  segment lines, active-low, bit order gfedcba (bit 6 = g, bit 0 = a).
- clear_i  input  1  synchronous clear of all captured state.
- digits_o  output  4*NUM_DIGITS  decoded nibbles; digit i occupies bits [4i+3:4i].
- valid_o  output  NUM_DIGITS  bit i set when digit i holds a legally decoded value.
- err_o  output  1  sticky flag; set on any illegal pattern captured.
- frame_o  output  1  one-cycle pulse when every digit has been captured since the last frame.

## Operation
- Decode table (seg_i to nibble): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=0111000, 8=0000000, 9=0011000, A=0001000, B=0000011, C=1000110, D=0100001, E=0000110, F=0001110.
- Blank pattern 1111111 is legal. It clears valid_o[i], leaves digits_o slot i unchanged, and does not set err_o.
- Any other pattern is illegal. It clears valid_o[i], leaves the slot unchanged, and sets err_o.
- Sample register: {an_i, seg_i} is registered every cycle. The run counter cnt resets to 0 when the new sample differs from the previous one; otherwise it increments, saturating at STABLE_CYCLES-1.
- FSM states:
  - IDLE: the sample is not exactly one-hot-low, i.e. zero or more than one anode low, which is treated as a blanking interval. No capture and no error in this state.
  - SETTLE: one-hot-low sample with cnt < STABLE_CYCLES-1.
  - HELD: capture done.
- Transitions:
  - SETTLE goes to HELD when cnt reaches STABLE_CYCLES-1. Exactly one capture is performed, into slot i = index of the low anode.
  - HELD stays in HELD while the sample is unchanged. There is no repeat capture and no repeat frame contribution.
  - Any sample change goes to SETTLE (one-hot) or IDLE (not one-hot).
- Frame tracking: an internal seen mask gets bit i set on every capture, whether legal, blank or illegal. When a capture makes the mask all-ones, frame_o pulses and the mask clears in the same update.
- clear_i: clears digits_o, valid_o, err_o, the seen mask and cnt, and forces IDLE. clear_i wins over a capture in the same cycle.

## Timing
- Reset values: digits_o = 0, valid_o = 0, err_o = 0, frame_o = 0, cnt = 0, state IDLE, seen mask = 0.
- Capture latency: if inputs are held constant for edges k through k+STABLE_CYCLES-1, digits_o, valid_o and err_o update at edge k+STABLE_CYCLES. With the default, the first sample is at edge k and the update is at edge k+4.
- A change at any edge inside the window restarts the count from that edge. A glitch of STABLE_CYCLES-1 cycles or fewer never captures.
- frame_o is asserted for exactly the one cycle following the completing capture edge, then low.
- Reset asserted mid-window: all state returns to reset values immediately, and the partial window is discarded.
- If an_i selects the same digit with a new pattern, it is a new window, and the later legal capture overwrites the slot.

## Test plan
- Reset then idle: rst_ni low for 3 cycles, then an_i=1111. Outputs stay at reset values, and frame_o never pulses.
- Full frame: digits 0..3 each held 8 cycles with patterns 3 (0110000), A (0001000), 7 (0111000), F (0001110).
  - Required: digits_o=16'hF7A3, valid_o=1111, err_o=0.
  - frame_o pulses once, 1 cycle after the digit-3 capture.
- Glitch rejection: digit 1 shows 0100100 for 3 cycles, then 1111001 for 6 cycles. Nibble 1 = 1, and digit 2 is never captured.
- Illegal and blank:
  - digit 2 = 1010101 for 5 cycles → err_o=1, valid_o[2]=0.
  - Then digit 2 = 1111111 → valid_o[2]=0, and err_o stays 1.
- Multi-anode blanking: an_i=1100 with segments 0000000 for 10 cycles. No capture and err_o unchanged.
- Clear priority: assert clear_i on the capture edge of digit 0 = 0010010. Outputs are all zero afterwards, and a subsequent stable window captures 5.
